kf8259_inta_sequencer: RTL and testbench

Generates the two-pulse interrupt-acknowledge bus cycle that the KF8259 requires. On a CPU-core request, it drives interrupt_acknowledge_n low twice with programmable pulse and gap widths. It captures the vector the controller drives on the second pulse and returns it to the core with a one-cycle valid strobe. It sits between the CPU bus-interface unit and the KF8259 instance, and holds off register accesses to the controller while a sequence is in progress.

---
 rtl/kf8259_inta_sequencer.sv | 178 +++++++++++++++++
 tb/tb_kf8259_inta_sequencer.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/kf8259_inta_sequencer.sv
// kf8259_inta_sequencer
//
// Runs the two-pulse interrupt-acknowledge cycle for a KF8259. The first
// INTA pulse tells the controller to freeze its priority resolution. The
// second pulse makes it drive the vector, which is captured and handed back
// to the CPU core with a one-cycle valid strobe.
//
// Parameters
//   INTA_LOW_CYCLES  cycles each INTA pulse is held low (1..255)
//   INTA_GAP_CYCLES  cycles INTA is high between the two pulses (1..255)
//   SPURIOUS_VECTOR  vector reported when the controller leaves the bus floating
//
// Optional feature macro: KF8259_INTA_AUTO_EN
//   Defined:   a sequence also starts when interrupt_to_cpu has been high for
//              two consecutive samples. After each completed sequence this
//              auto-start is re-armed only by a low sample of interrupt_to_cpu.
//   Undefined: only vector_request starts a sequence.
//
// Ports
//   clock, reset            single clock, synchronous active-high reset
//   vector_request          one-cycle start request from the CPU core
//   interrupt_to_cpu        INT from the KF8259 (used only with auto-start)
//   pic_data_bus_out        KF8259 data output
//   pic_data_bus_io         0 while the KF8259 drives pic_data_bus_out
//   interrupt_acknowledge_n INTA strobe to the KF8259, active low
//   lock_n                  bus lock, low from the first pulse to the end of the second
//   busy                    high in every state except IDLE
//   vector_valid            one-cycle strobe: vector was just updated
//   vector                  last captured vector (cleared only by reset)
//   request_dropped         one-cycle pulse: a request arrived while busy
//   debug_state             current FSM state, for checkers
//
// Handshake: vector_request is a one-cycle strobe with no ready. It is
// accepted only when busy is low at the sampling edge. Otherwise it is
// discarded and request_dropped pulses on the next cycle. vector_valid is a
// one-cycle strobe with no back-pressure. The core must take vector in that
// cycle or read it later, because vector holds its value until the next capture.
//
// All outputs are registered. Each output is written at the same edge that
// moves the FSM into the state the output describes.

module kf8259_inta_sequencer #(
  parameter int unsigned INTA_LOW_CYCLES = 4,
  parameter int unsigned INTA_GAP_CYCLES = 2,
  parameter logic [7:0]  SPURIOUS_VECTOR = 8'hFF
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       vector_request,
  input  logic       interrupt_to_cpu,
  input  logic [7:0] pic_data_bus_out,
  input  logic       pic_data_bus_io,
  output logic       interrupt_acknowledge_n,
  output logic       lock_n,
  output logic       busy,
  output logic       vector_valid,
  output logic [7:0] vector,
  output logic       request_dropped,
  output logic [2:0] debug_state
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    INTA1 = 3'd1,
    GAP   = 3'd2,
    INTA2 = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam logic [7:0] LOW_LOAD = 8'(INTA_LOW_CYCLES - 1);
  localparam logic [7:0] GAP_LOAD = 8'(INTA_GAP_CYCLES - 1);

  state_t     state;
  logic [7:0] counter;
  logic       start;

  assign debug_state = state;

`ifdef KF8259_INTA_AUTO_EN
  // int_q holds the previous sample of INT. Two high samples in a row
  // qualify an auto-start, which filters out single-cycle glitches.
  logic int_q;
  logic auto_armed;

  assign start = vector_request | (interrupt_to_cpu & int_q & auto_armed);
`else
  logic unused_interrupt_to_cpu;

  assign unused_interrupt_to_cpu = interrupt_to_cpu;
  assign start = vector_request;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state                   <= IDLE;
      counter                 <= 8'd0;
      interrupt_acknowledge_n <= 1'b1;
      lock_n                  <= 1'b1;
      busy                    <= 1'b0;
      vector_valid            <= 1'b0;
      vector                  <= 8'h00;
      request_dropped         <= 1'b0;
`ifdef KF8259_INTA_AUTO_EN
      int_q                   <= 1'b0;
      auto_armed              <= 1'b1;
`endif
    end else begin
      vector_valid    <= 1'b0;
      request_dropped <= vector_request && (state != IDLE);

`ifdef KF8259_INTA_AUTO_EN
      int_q <= interrupt_to_cpu;
      // Completing a sequence disarms auto-start. A later low sample of
      // INT re-arms it, so a level that stays high cannot retrigger.
      if (state == INTA2 && counter == 8'd0) begin
        auto_armed <= 1'b0;
      end else if (!interrupt_to_cpu) begin
        auto_armed <= 1'b1;
      end
`endif

      case (state)
        IDLE: begin
          if (start) begin
            state                   <= INTA1;
            counter                 <= LOW_LOAD;
            interrupt_acknowledge_n <= 1'b0;
            lock_n                  <= 1'b0;
            busy                    <= 1'b1;
          end
        end
        INTA1: begin
          if (counter == 8'd0) begin
            state                   <= GAP;
            counter                 <= GAP_LOAD;
            interrupt_acknowledge_n <= 1'b1;
          end else begin
            counter <= counter - 8'd1;
          end
        end
        GAP: begin
          if (counter == 8'd0) begin
            state                   <= INTA2;
            counter                 <= LOW_LOAD;
            interrupt_acknowledge_n <= 1'b0;
          end else begin
            counter <= counter - 8'd1;
          end
        end
        INTA2: begin
          if (counter == 8'd0) begin
            // Sample the bus on the edge that ends the second pulse. A
            // floating bus means the controller did not answer.
            state                   <= DONE;
            vector                  <= pic_data_bus_io ? SPURIOUS_VECTOR : pic_data_bus_out;
            vector_valid            <= 1'b1;
            interrupt_acknowledge_n <= 1'b1;
            lock_n                  <= 1'b1;
          end else begin
            counter <= counter - 8'd1;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state                   <= IDLE;
          counter                 <= 8'd0;
          interrupt_acknowledge_n <= 1'b1;
          lock_n                  <= 1'b1;
          busy                    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_kf8259_inta_sequencer.sv
// Testbench for kf8259_inta_sequencer.
//
// Two instances share the same inputs. One uses the default timing (L=4,
// G=2). The other uses the minimum timing (L=1, G=1). The reference model
// describes each sequence as a timeline. Cycle k after the accepting edge
// is classified by plain arithmetic on L and G, with no FSM inside the model.
// Captured vectors go into a per-instance expected queue. That queue is
// drained whenever a DUT raises vector_valid.

module tb_kf8259_inta_sequencer;

  localparam int L0 = 4;
  localparam int G0 = 2;
  localparam int L1 = 1;
  localparam int G1 = 1;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic       reset = 1'b1;
  logic       vector_request = 1'b0;
  logic       interrupt_to_cpu = 1'b0;
  logic [7:0] pic_data_bus_out = 8'h00;
  logic       pic_data_bus_io = 1'b1;

  logic       inta_n_0, lock_n_0, busy_0, valid_0, drop_0;
  logic [7:0] vector_0;
  logic [2:0] state_0;
  logic       inta_n_1, lock_n_1, busy_1, valid_1, drop_1;
  logic [7:0] vector_1;
  logic [2:0] state_1;

  kf8259_inta_sequencer #(
    .INTA_LOW_CYCLES(L0), .INTA_GAP_CYCLES(G0), .SPURIOUS_VECTOR(8'hFF)
  ) dut (
    .clock(clock), .reset(reset), .vector_request(vector_request),
    .interrupt_to_cpu(interrupt_to_cpu), .pic_data_bus_out(pic_data_bus_out),
    .pic_data_bus_io(pic_data_bus_io), .interrupt_acknowledge_n(inta_n_0),
    .lock_n(lock_n_0), .busy(busy_0), .vector_valid(valid_0), .vector(vector_0),
    .request_dropped(drop_0), .debug_state(state_0)
  );

  kf8259_inta_sequencer #(
    .INTA_LOW_CYCLES(L1), .INTA_GAP_CYCLES(G1), .SPURIOUS_VECTOR(8'hFF)
  ) dut_min (
    .clock(clock), .reset(reset), .vector_request(vector_request),
    .interrupt_to_cpu(interrupt_to_cpu), .pic_data_bus_out(pic_data_bus_out),
    .pic_data_bus_io(pic_data_bus_io), .interrupt_acknowledge_n(inta_n_1),
    .lock_n(lock_n_1), .busy(busy_1), .vector_valid(valid_1), .vector(vector_1),
    .request_dropped(drop_1), .debug_state(state_1)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0] exp_q0[$];
  logic [7:0] exp_q1[$];
  int         valid_seen[2];

  // Timeline model per instance: m_k is the cycle index since the accepting edge.
  int         m_l[2];
  int         m_g[2];
  bit         m_active[2];
  int         m_k[2];
  logic [7:0] m_vec[2];
  bit         m_drop[2];
  bit         m_int_q[2];
  bit         m_armed[2];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  task automatic model_reset_all();
    for (int i = 0; i < 2; i++) begin
      m_active[i] = 1'b0;
      m_k[i]      = 0;
      m_vec[i]    = 8'h00;
      m_drop[i]   = 1'b0;
      m_int_q[i]  = 1'b0;
      m_armed[i]  = 1'b1;
    end
    exp_q0.delete();
    exp_q1.delete();
  endtask

  // Called just after each rising edge. The inputs still hold the values
  // the DUT sampled at that edge.
  task automatic model_edge();
    if (reset) begin
      model_reset_all();
      return;
    end
    for (int i = 0; i < 2; i++) begin
      int  last;
      bit  start;
      bit  entered_done;
      last         = 2 * m_l[i] + m_g[i] + 1;
      entered_done = 1'b0;
      start        = vector_request;
`ifdef KF8259_INTA_AUTO_EN
      start = start | (interrupt_to_cpu & m_int_q[i] & m_armed[i]);
`endif
      m_drop[i] = vector_request & m_active[i];
      if (m_active[i]) begin
        if (m_k[i] == last) begin
          m_active[i] = 1'b0;
        end else begin
          if (m_k[i] == last - 1) begin
            m_vec[i] = pic_data_bus_io ? 8'hFF : pic_data_bus_out;
            if (i == 0) exp_q0.push_back(m_vec[i]);
            else        exp_q1.push_back(m_vec[i]);
            entered_done = 1'b1;
          end
          m_k[i]++;
        end
      end else if (start) begin
        m_active[i] = 1'b1;
        m_k[i]      = 1;
      end
      if (entered_done)           m_armed[i] = 1'b0;
      else if (!interrupt_to_cpu) m_armed[i] = 1'b1;
      m_int_q[i] = interrupt_to_cpu;
    end
  endtask

  task automatic check_dut(input int i, input logic inta_n, input logic lock_n,
                           input logic busy, input logic valid, input logic [7:0] vec,
                           input logic drop);
    int       l;
    int       g;
    int       k;
    bit       act;
    bit       e_inta_low;
    logic [7:0] qv;
    l   = m_l[i];
    g   = m_g[i];
    k   = m_k[i];
    act = m_active[i];
    e_inta_low = act && ((k >= 1 && k <= l) || (k >= l + g + 1 && k <= 2 * l + g));
    check_eq($sformatf("u%0d_inta_n", i), inta_n, !e_inta_low);
    check_eq($sformatf("u%0d_lock_n", i), lock_n, !(act && k <= 2 * l + g));
    check_eq($sformatf("u%0d_busy", i), busy, act);
    check_eq($sformatf("u%0d_valid", i), valid, act && k == 2 * l + g + 1);
    check_eq($sformatf("u%0d_vector", i), vec, m_vec[i]);
    check_eq($sformatf("u%0d_dropped", i), drop, m_drop[i]);
    if (valid) begin
      valid_seen[i]++;
      if (i == 0 && exp_q0.size() != 0) begin
        qv = exp_q0.pop_front();
        check_eq("u0_sb_vector", vec, qv);
      end else if (i == 1 && exp_q1.size() != 0) begin
        qv = exp_q1.pop_front();
        check_eq("u1_sb_vector", vec, qv);
      end else begin
        check_eq($sformatf("u%0d_sb_unexpected_valid", i), 1, 0);
      end
    end
  endtask

  // ---------------- driver ----------------
  task automatic step();
    @(posedge clock);
    model_edge();
    @(negedge clock);
    check_dut(0, inta_n_0, lock_n_0, busy_0, valid_0, vector_0, drop_0);
    check_dut(1, inta_n_1, lock_n_1, busy_1, valid_1, vector_1, drop_1);
  endtask

  task automatic run(input int n);
    for (int c = 0; c < n; c++) step();
  endtask

  task automatic pulse_request();
    vector_request = 1'b1;
    step();
    vector_request = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    m_l[0] = L0; m_g[0] = G0;
    m_l[1] = L1; m_g[1] = G1;
    valid_seen[0] = 0;
    valid_seen[1] = 0;
    model_reset_all();

    // Reset state.
    reset = 1'b1;
    run(2);
    reset = 1'b0;
    check_eq("reset_inta_n", inta_n_0, 1);
    check_eq("reset_lock_n", lock_n_0, 1);
    check_eq("reset_busy", busy_0, 0);
    check_eq("reset_vector", vector_0, 8'h00);
    run(1);

    // Controller drives 0x0A on the second pulse.
    pic_data_bus_io  = 1'b0;
    pic_data_bus_out = 8'h0A;
    pulse_request();
    run(12);
    check_eq("t1_vector_default", vector_0, 8'h0A);
    check_eq("t1_vector_min", vector_1, 8'h0A);

    // Bus left floating: the spurious vector is reported.
    pic_data_bus_io = 1'b1;
    pulse_request();
    run(12);
    check_eq("t2_vector_spurious", vector_0, 8'hFF);

    // Request during a running sequence is dropped and not queued.
    pic_data_bus_io  = 1'b0;
    pic_data_bus_out = 8'h5C;
    valid_seen[0] = 0;
    valid_seen[1] = 0;
    pulse_request();
    run(2);
    pulse_request();
    check_eq("t3_dropped_flag", drop_0, 1);
    run(16);
    check_eq("t3_single_valid_default", valid_seen[0], 1);
    check_eq("t3_single_valid_min", valid_seen[1], 1);

    // Reset during the gap abandons the sequence.
    pulse_request();
    run(4);
    check_eq("t4_in_gap", inta_n_0, 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check_eq("t4_inta_n", inta_n_0, 1);
    check_eq("t4_lock_n", lock_n_0, 1);
    check_eq("t4_busy", busy_0, 0);
    check_eq("t4_vector", vector_0, 8'h00);
    run(12);

    // Randomized traffic.
    for (int c = 0; c < 4000; c++) begin
      vector_request   = ($urandom_range(0, 7) == 0);
      interrupt_to_cpu = ($urandom_range(0, 3) != 0);
      pic_data_bus_io  = ($urandom_range(0, 3) == 0);
      pic_data_bus_out = 8'($urandom_range(0, 255));
      reset            = ($urandom_range(0, 299) == 0);
      step();
    end
    vector_request = 1'b0;
    reset          = 1'b0;
    run(20);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
